mem_arbiter: RTL and testbench

//  Arbitrates the single multicycle main memory between the I-cache and D-cache fill FSMs and D-cache write-through stores.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_ret_counter.sv | 38 +++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding, burst length
// and return-counter width.
package mem_arbiter_pkg;

  // Returns per line fill (16-byte line, 2-byte words).
  localparam int unsigned ArbWords = 8;

  // Return counter width; never wraps because it clears at ArbWords.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIFill = 2'b01,
    StDFill = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_ret_counter.sv
// Counts memory returns within a line burst. done pulses on the increment that
// brings the count to WORDS, and the counter clears itself on that same edge.
module mem_arbiter_ret_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORDS = ArbWords
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [CntW-1:0] count_q, count_d;

  assign done = inc && (count_q == CntW'(WORDS - 1));

  // Next count: clear wins, then self-clear on the final return, else increment.
  always_comb begin
    count_d = count_q;
    if (clr || done) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main memory between the I-fill FSM, the D-fill FSM and
// D-cache write-through stores. A fill owner keeps the memory for a whole line
// burst; returns are routed only to the owner and dropped while idle.
// Build option: define ARB_ROUND_ROBIN_EN to alternate between I and D fills
// when both are pending; otherwise D fills always win over I fills.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORDS = ArbWords,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic          d_req,
  input  logic          d_en,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wreq,
  input  logic [AW-1:0] d_waddr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          i_grant,
  output logic          d_grant,
  output logic          d_wgrant,
  output logic          i_valid,
  output logic          d_valid,
  output logic [DW-1:0] rd_data
);

  arb_state_e state_q, state_d;
  logic       pick_d, pick_i;
  logic       cnt_clr, cnt_inc, cnt_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;  // 0 = D owned last, 1 = I owned last

  // Idle fill choice: stores first, then alternate when both fills pend.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (!d_wreq) begin
      if (d_req && i_req) begin
        pick_i = !last_owner_q;
        pick_d = last_owner_q;
      end else begin
        pick_d = d_req;
        pick_i = i_req;
      end
    end
  end

  // Remember which side took the most recent fill grant.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == StIdle && (pick_d || pick_i)) begin
      last_owner_d = pick_i;
    end
  end

  // Last-owner register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Idle fill choice: fixed priority store > D fill > I fill.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (!d_wreq) begin
      pick_d = d_req;
      pick_i = i_req && !d_req;
    end
  end
`endif

  mem_arbiter_ret_counter #(
    .WORDS (WORDS)
  ) u_ret_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  // Next state and return-counter control; counter is held clear while idle.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (pick_d) begin
          state_d = StDFill;
        end else if (pick_i) begin
          state_d = StIFill;
        end
      end
      StIFill: begin
        cnt_inc = mem_valid;
        // Release on the last return or when the owner aborts.
        if (!i_req || cnt_done) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      end
      StDFill: begin
        cnt_inc = mem_valid;
        if (!d_req || cnt_done) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Output steering; everything is forced low while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    d_wgrant  = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    rd_data   = '0;
    if (!rst) begin
      rd_data = mem_rdata;
      unique case (state_q)
        StIdle: begin
          // Grants here are combinational so the first enable is not delayed.
          if (d_wreq) begin
            d_wgrant  = 1'b1;
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_waddr;
            mem_wdata = d_wdata;
          end else if (pick_d) begin
            d_grant  = 1'b1;
            mem_en   = d_en;
            mem_addr = d_addr;
          end else if (pick_i) begin
            i_grant  = 1'b1;
            mem_en   = i_en;
            mem_addr = i_addr;
          end
        end
        StIFill: begin
          i_grant  = 1'b1;
          mem_en   = i_en;
          mem_addr = i_addr;
          i_valid  = mem_valid;
        end
        StDFill: begin
          d_grant  = 1'b1;
          mem_en   = d_en;
          mem_addr = d_addr;
          d_valid  = mem_valid;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, i_en, d_req, d_en, d_wreq;
  logic [15:0] i_addr, d_addr, d_waddr, d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        i_grant, d_grant, d_wgrant, i_valid, d_valid;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int leak_cnt = 0;
  logic force_in = 1'b0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_en      (i_en),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_en      (d_en),
    .d_addr    (d_addr),
    .d_wreq    (d_wreq),
    .d_waddr   (d_waddr),
    .d_wdata   (d_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .i_grant   (i_grant),
    .d_grant   (d_grant),
    .d_wgrant  (d_wgrant),
    .i_valid   (i_valid),
    .d_valid   (d_valid),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data = addr ^ 0xA5A5, valid 4 cycles after the enable.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4] = '{default: '0};
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_valid = pv[3] | force_in;
  assign mem_rdata = force_in ? 16'hFFFF : (pa[3] ^ 16'hA5A5);

  // I-side addresses (0x123x) must never appear while D owns memory.
  always @(negedge clk) begin
    if (d_grant && mem_en && mem_addr[15:4] == 12'h123) leak_cnt <= leak_cnt + 1;
  end

  task automatic run_fill(input bit side_d, input logic [15:0] base, output int first_g,
                          output int last_v, output int nvalid, output int nbad,
                          output int nother);
    int   sent;
    int   guard;
    logic g;
    sent = 0; guard = 0; first_g = -1; last_v = -1; nvalid = 0; nbad = 0; nother = 0;
    if (side_d) d_req = 1'b1; else i_req = 1'b1;
    #1;
    while (nvalid < 8 && guard < 200) begin
      g = side_d ? d_grant : i_grant;
      if (g && first_g < 0) first_g = cyc;
      if (side_d) begin
        d_en   = g && sent < 8;
        d_addr = base + 16'(2 * sent);
      end else begin
        i_en   = g && sent < 8;
        i_addr = base + 16'(2 * sent);
      end
      if (g && sent < 8) sent++;
      @(negedge clk);
      if (side_d ? d_valid : i_valid) begin
        if (rd_data !== ((base + 16'(2 * nvalid)) ^ 16'hA5A5)) nbad++;
        nvalid++;
        last_v = cyc;
      end
      if (side_d ? i_valid : d_valid) nother++;
      @(posedge clk);
      guard++;
      if (nvalid < 8) #2;
    end
    #1;
    if (side_d) begin d_req = 1'b0; d_en = 1'b0; end
    else begin i_req = 1'b0; i_en = 1'b0; end
  endtask

  task automatic do_store(input int delay, input logic [15:0] a, input logic [15:0] d,
                          output int gcyc, output int nwr, output logic [15:0] ga,
                          output logic [15:0] gd);
    repeat (delay) @(posedge clk);
    #1;
    d_wreq = 1'b1; d_waddr = a; d_wdata = d;
    gcyc = -1; nwr = 0; ga = '0; gd = '0;
    for (int k = 0; k < 200 && gcyc < 0; k++) begin
      @(negedge clk);
      if (mem_wr) nwr++;
      if (d_wgrant) begin gcyc = cyc; ga = mem_addr; gd = mem_wdata; end
      @(posedge clk);
      #1;
    end
    d_wreq = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr) nwr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; force_in = 1'b1;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'hFFFF;
    d_req = 1'b1; d_en = 1'b1; d_addr = 16'hFFFF;
    d_wreq = 1'b1; d_waddr = 16'hFFFF; d_wdata = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, d_wgrant, i_valid, d_valid,
           rd_data} !== 55'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got en=%b wr=%b addr=%h gi=%b gd=%b gw=%b vi=%b vd=%b rd=%h, need all 0",
                 k, mem_en, mem_wr, mem_addr, i_grant, d_grant, d_wgrant, i_valid, d_valid,
                 rd_data);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0; force_in = 1'b0;
    i_req = 1'b0; i_en = 1'b0; i_addr = '0;
    d_req = 1'b0; d_en = 1'b0; d_addr = '0;
    d_wreq = 1'b0; d_waddr = '0; d_wdata = '0;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: got %b, need 00", dut.state_q);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_fill();
    int fg, lv, nv, nb, no, extra;
    run_fill(1'b0, 16'h1230, fg, lv, nv, nb, no);
    n_checks++;
    if (nv !== 8) begin n_fail++; $display("FAIL ifill_count: got %0d, need 8", nv); end
    n_checks++;
    if (nb !== 0) begin n_fail++; $display("FAIL ifill_rdata: got %0d bad words, need 0", nb); end
    n_checks++;
    if (no !== 0) begin n_fail++; $display("FAIL ifill_dvalid: got %0d d_valid, need 0", no); end
    n_checks++;
    if (lv - fg !== 11) begin
      n_fail++;
      $display("FAIL ifill_latency: got %0d cycles grant-to-last, need 11", lv - fg);
    end
    @(negedge clk);
    n_checks++;
    if (i_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL ifill_release: got i_grant=%b after 8th valid, need 0", i_grant);
    end
    extra = i_valid ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (i_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ifill_extra: got %0d, need 0", extra); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    int dfg, dlv, dnv, dnb, dno, ifg, ilv, inv, inb, ino, leak0;
    leak0 = leak_cnt;
    fork
      run_fill(1'b1, 16'h5670, dfg, dlv, dnv, dnb, dno);
      run_fill(1'b0, 16'h1230, ifg, ilv, inv, inb, ino);
    join
    @(posedge clk);
    #1;
    n_checks++;
    if (!(dfg >= 0 && dfg < ifg)) begin
      n_fail++;
      $display("FAIL contend_order: got d first=%0d i first=%0d, need D first", dfg, ifg);
    end
    n_checks++;
    if (ifg !== dlv + 1) begin
      n_fail++;
      $display("FAIL contend_handoff: got i grant cycle %0d, need %0d", ifg, dlv + 1);
    end
    n_checks++;
    if (leak_cnt - leak0 !== 0) begin
      n_fail++;
      $display("FAIL contend_leak: got %0d I addresses during D fill, need 0", leak_cnt - leak0);
    end
    n_checks++;
    if (dnv !== 8 || inv !== 8) begin
      n_fail++;
      $display("FAIL contend_counts: got d=%0d i=%0d, need 8 and 8", dnv, inv);
    end
    n_checks++;
    if (dnb + inb !== 0) begin
      n_fail++;
      $display("FAIL contend_rdata: got %0d bad words, need 0", dnb + inb);
    end
  endtask

  task automatic test_store_during_fill();
    int fg, lv, nv, nb, no, gc, nwr;
    logic [15:0] ga, gd;
    fork
      run_fill(1'b0, 16'h1230, fg, lv, nv, nb, no);
      do_store(3, 16'h0040, 16'hBEEF, gc, nwr, ga, gd);
    join
    @(posedge clk);
    #1;
    n_checks++;
    if (nv !== 8) begin n_fail++; $display("FAIL store_fill_count: got %0d, need 8", nv); end
    n_checks++;
    if (gc !== lv + 1) begin
      n_fail++;
      $display("FAIL store_grant_cycle: got %0d, need %0d", gc, lv + 1);
    end
    n_checks++;
    if (nwr !== 1) begin n_fail++; $display("FAIL store_wr_cycles: got %0d, need 1", nwr); end
    n_checks++;
    if (ga !== 16'h0040) begin n_fail++; $display("FAIL store_addr: got %h, need 0040", ga); end
    n_checks++;
    if (gd !== 16'hBEEF) begin n_fail++; $display("FAIL store_data: got %h, need beef", gd); end
  endtask

  task automatic test_reset_midburst();
    int sent, got, guard, stale, leaked;
    sent = 0; got = 0; guard = 0; stale = 0; leaked = 0;
    d_req = 1'b1;
    #1;
    while (got < 3 && guard < 50) begin
      if (d_grant && sent < 8) begin
        d_en = 1'b1; d_addr = 16'h5670 + 16'(2 * sent); sent++;
      end else begin
        d_en = 1'b0;
      end
      @(negedge clk);
      if (d_valid) got++;
      @(posedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (got !== 3) begin n_fail++; $display("FAIL midrst_prefix: got %0d valids, need 3", got); end
    rst = 1'b1; d_req = 1'b0; d_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en, d_grant, i_grant, d_valid, i_valid, rd_data} !== 21'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got en=%b gd=%b gi=%b vd=%b vi=%b rd=%h, need all 0",
               mem_en, d_grant, i_grant, d_valid, i_valid, rd_data);
    end
    if (mem_valid) stale++;
    if (d_valid || i_valid) leaked++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_valid) stale++;
      if (d_valid || i_valid) leaked++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (stale !== 4) begin n_fail++; $display("FAIL midrst_stale: got %0d, need 4", stale); end
    n_checks++;
    if (leaked !== 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d, need 0", leaked); end
  endtask

  task automatic test_back_to_back();
    int exp_order [3];
    int got_order [3];
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 2, 1};
`else
    exp_order = '{2, 2, 2};
`endif
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      int   sent, got, guard;
      bit   side_d;
      logic g;
      sent = 0; got = 0; guard = 0;
      #1;
      side_d = d_grant;
      got_order[n] = d_grant ? 2 : (i_grant ? 1 : 0);
      while (got < 8 && guard < 60) begin
        g = side_d ? d_grant : i_grant;
        if (side_d) begin d_en = g && sent < 8; d_addr = 16'h5670 + 16'(2 * sent); end
        else begin i_en = g && sent < 8; i_addr = 16'h1230 + 16'(2 * sent); end
        if (g && sent < 8) sent++;
        @(negedge clk);
        if (side_d ? d_valid : i_valid) got++;
        @(posedge clk);
        #1;
        guard++;
      end
      d_en = 1'b0; i_en = 1'b0;
      n_checks++;
      if (got_order[n] !== exp_order[n]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got %0d, need %0d (1=I 2=D)", n, got_order[n],
                 exp_order[n]);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_en = 1'b0; i_addr = '0;
    d_req = 1'b0; d_en = 1'b0; d_addr = '0;
    d_wreq = 1'b0; d_waddr = '0; d_wdata = '0;
    test_reset();
    test_single_fill();
    test_contention();
    test_store_during_fill();
    test_reset_midburst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
